// File: rtl/request_latch.sv
// request_latch: synchronise, debounce and latch car/hall buttons into pending elevator requests
module request_latch #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] btn_in,
   input  logic [9:0] btn_out,
   input  logic [2:0] onow,
   input  logic       door_open,
   input  logic       dir_up,
   output logic [5:0] input_in,
   output logic [9:0] input_out,
   output logic       any_req
);
   localparam int N = 16;
   logic [N-1:0]     raw, s1_q, s2_q, db_q, db_d, dly_q, arm_q, arm_d, rise, set_v, clr, req_q, req_d;
   logic [CNT_W-1:0] cnt_q [N];
   logic [CNT_W-1:0] cnt_d [N];
   logic [1:0]       rdy_q;
   logic             any_q;
   assign raw = {btn_out, btn_in};
   for (genvar l = 0; l < N; l++) begin : g_lane
      logic             diff, hit;
      logic [CNT_W-1:0] inc;
      assign diff     = s2_q[l] != db_q[l];
      assign inc      = cnt_q[l] + CNT_W'(1);
      assign hit      = diff && inc == CNT_W'(DEBOUNCE_CYCLES);
      assign cnt_d[l] = (diff && !hit) ? inc : '0;
      assign db_d[l]  = db_q[l] ^ hit;
   end
   // a lane may only set a request once its synchronised level has been seen low after reset,
   // so a button held through reset needs a release-and-press to register
   assign rise  = db_q & ~dly_q;
   assign arm_d = arm_q | ({N{rdy_q[1]}} & ~s2_q & ~db_q);
   assign set_v = rise & arm_q;
   // door open at a valid floor serves the car call and the hall call matching the travel direction
   always_comb begin
      clr = '0;
      if (door_open && onow <= 3'd5) begin
         clr[onow] = 1'b1;
         if (onow <= 3'd4 && (dir_up || onow == 3'd0)) clr[4'd6 + 4'(onow)] = 1'b1;
         if (onow >= 3'd1 && (!dir_up || onow == 3'd5)) clr[4'd10 + 4'(onow)] = 1'b1;
      end
   end
   assign req_d = (req_q | set_v) & ~clr;
   // all lane state plus the sticky request vector and its registered OR
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= '0;
         s2_q  <= '0;
         db_q  <= '0;
         dly_q <= '0;
         arm_q <= '0;
         req_q <= '0;
         any_q <= 1'b0;
         rdy_q <= '0;
         cnt_q <= '{default: '0};
      end else begin
         s1_q  <= raw;
         s2_q  <= s1_q;
         db_q  <= db_d;
         dly_q <= db_q;
         arm_q <= arm_d;
         req_q <= req_d;
         any_q <= |req_d;
         rdy_q <= {rdy_q[0], 1'b1};
         cnt_q <= cnt_d;
      end
   end
   assign input_in  = req_q[5:0];
   assign input_out = req_q[15:6];
   assign any_req   = any_q;
endmodule
